// File: rtl/mips_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake,
// and holds each instruction until the decoder consumes it or fetch halts.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic [1:0]  control_type,
  input  logic        except,
  input  logic        stall,
  input  logic [31:0] rs_data,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] retired
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [1:0] CT_SEQ    = 2'd0;
  localparam logic [1:0] CT_BRANCH = 2'd1;
  localparam logic [1:0] CT_JUMP   = 2'd2;
  localparam logic [1:0] CT_JR     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] retired_q, retired_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] pc4_s;
  logic [31:0] next_pc_s;

  // Branch offsets are word-scaled; jumps keep the top nibble of pc+4.
  function automatic logic [31:0] next_pc_f(
    input logic [1:0]  ctype,
    input logic [31:0] seq_pc,
    input logic [31:0] word,
    input logic [31:0] rs
  );
    logic [31:0] result;
    case (ctype)
      CT_SEQ:    result = seq_pc;
      CT_BRANCH: result = seq_pc + {{14{word[15]}}, word[15:0], 2'b00};
      CT_JUMP:   result = {seq_pc[31:28], word[25:0], 2'b00};
      CT_JR:     result = rs;
      default:   result = seq_pc;
    endcase
    return result;
  endfunction

  assign pc4_s     = pc_q + 32'd4;
  assign next_pc_s = next_pc_f(control_type, pc4_s, inst_q, rs_data);

  // Next-state logic for the fetch FSM and its architectural registers.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    retired_d    = retired_q;
    misaligned_d = misaligned_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (except) begin
          state_d = ST_HALT;
        end else if (stall) begin
          state_d = ST_EXEC;
        end else begin
          // A misaligned target still retires the instruction that produced it.
          retired_d = retired_q + 32'd1;
          if (next_pc_s[1:0] != 2'b00) begin
            misaligned_d = 1'b1;
            state_d      = ST_HALT;
          end else begin
            pc_d    = next_pc_s;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // State registers; reset discards any response still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      retired_q    <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      retired_q    <= retired_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_req   = (state_q == ST_FETCH);
  assign inst_valid = (state_q == ST_EXEC);
  assign halted     = (state_q == ST_HALT);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign pc4        = pc4_s;
  assign inst       = inst_q;
  assign retired    = retired_q;
  assign misaligned = misaligned_q;

endmodule

// File: doc/mips_fetch.md
Name: mips_fetch

Overview:
- Instruction-fetch stage directly upstream of mips_decode in the MIPS machine.
- Owns the PC and fetches instruction words over a variable-latency req/ack handshake to instruction memory.
- Presents the held instruction word to the decoder; the decoder takes opcode=inst[31:26] and funct=inst[5:0].
- Consumes the decoder's control_type and except outputs to select the next PC, and stops fetching on an exception or a misaligned target.

Parameters:
- RESET_PC, 32'h00400000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  memory response valid; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- inst  out  32  held instruction word, to decoder and datapath.
- inst_valid  out  1  inst is valid and awaiting consumption.
- pc  out  32  address of the current instruction.
- pc4  out  32  pc+4, modulo 2^32.
- control_type  in  2  from decoder: 0=sequential, 1=branch taken, 2=jump, 3=jr.
- except  in  1  from decoder: unrecognised instruction.
- stall  in  1  downstream busy; hold the current instruction.
- rs_data  in  32  register rs value, used as the jr target.
- halted  out  1  fetch permanently stopped until reset.
- misaligned  out  1  halt was caused by a target with bits [1:0] != 0.
- retired  out  32  count of consumed instructions.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=RESET_PC, inst=0.
  - inst_valid=0, imem_req=0, halted=0, misaligned=0, retired=0.
  - A response in flight when reset asserts is discarded. A late imem_ack arriving while imem_req=0 is ignored.
- State machine:
  - IDLE: imem_req=0. Moves to FETCH on the first clock edge after reset deasserts.
  - FETCH:
    - imem_req=1, imem_addr=pc.
    - imem_req and imem_addr stay stable until an edge samples imem_ack=1.
    - On that edge: inst<=imem_rdata, go to EXEC.
    - Minimum latency is one cycle (ack present in the first FETCH cycle).
  - EXEC:
    - inst_valid=1, imem_req=0.
    - except has the highest priority: go to HALT, halted=1, pc unchanged, retired unchanged.
    - Otherwise, if stall=1: hold all state.
    - Otherwise the instruction is consumed:
      - retired+=1 (wraps at 2^32).
      - If next_pc[1:0]!=0: go to HALT with misaligned=1 and pc unchanged.
      - Otherwise pc<=next_pc and go to FETCH.
  - HALT: inst_valid=0, imem_req=0, halted=1. Only reset exits this state.
- next_pc, all arithmetic 32-bit and wrapping:
  - control_type 0: pc4.
  - control_type 1: pc4 + (signext(inst[15:0]) << 2).
  - control_type 2: {pc4[31:28], inst[25:0], 2'b00}.
  - control_type 3: rs_data.
- Output timing:
  - control_type, except and rs_data are sampled only in EXEC; they are don't-care in other states.
  - pc, pc4, inst and retired are registered or derived from registers. Nothing is combinational from imem_rdata.
  - inst_valid and imem_req decode directly from state.
- Throughput: at least 2 cycles per instruction (FETCH + EXEC). Fetches never overlap.
- Simultaneous events:
  - except together with stall → HALT.
  - A misaligned target is counted as retired (the jr consumed), then fetch halts.

Test Plan:
- Release reset, then hold imem_ack=1 → FETCH with imem_addr=0x00400000. On the next edge inst latches and inst_valid=1. With control_type=0 and stall=0: pc=0x00400004, retired=1, imem_req=1.
- At pc=0x00400010 with inst[15:0]=0x0003 and control_type=1 → next imem_addr=0x00400020. With inst[15:0]=0xFFFF → 0x00400010.
- At pc=0x00400020 with inst[25:0]=0x0100040 and control_type=2 → 0x00400100. With control_type=3 and rs_data=0x10000000 → imem_addr=0x10000000.
- control_type=3 with rs_data=0x00400102 → halted=1, misaligned=1, retired incremented, imem_req stays 0 for 10 or more cycles.
- Delay imem_ack by 4 cycles → imem_req=1 and imem_addr stable throughout. Then hold stall=1 for 3 cycles in EXEC → inst, pc and retired unchanged; advances on the first cycle with stall=0.
- except=1 in EXEC → halted=1, pc and retired unchanged. Assert reset mid-FETCH with an ack pending → pc=0x00400000, all outputs at reset values, and the stale ack is ignored.
